cnn_classify_ctrl: RTL and testbench



---
 rtl/cnn_pkg.sv | 23 ++
 rtl/argmax_seq.sv | 70 +++++++
 rtl/cnn_classify_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cnn_classify_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the classifier controller slice.
//   - state_t     : frame sequencer states
//   - CNN_N / CNN_NUM_CLASSES : default score width and class count
//   - score_lsb() : bit offset of class k inside a packed score vector
package cnn_pkg;

  localparam int CNN_N           = 8;
  localparam int CNN_NUM_CLASSES = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED   = 3'd1,
    WAIT   = 3'd2,
    ARGMAX = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Class k occupies bits [k*n +: n] of the packed score vector.
  function automatic int score_lsb(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/argmax_seq.sv
// argmax_seq: sequential signed argmax, one class per enabled cycle.
// Ports:
//   clk, rst (sync, active-high), ce (clock enable)
//   start      : load class 0 as best and begin scanning at class 1
//   scores     : packed signed scores, class k at [k*N +: N]
//   done       : high in the cycle the last class is compared
//   best_class : winning index including the current compare (valid with done)
//   best_score : winning score including the current compare (valid with done)
module argmax_seq
  import cnn_pkg::*;
#(
  parameter int N           = CNN_N,
  parameter int NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     start,
  input  logic [NUM_CLASSES*N-1:0] scores,
  output logic                     done,
  output logic [CLASS_W-1:0]       best_class,
  output logic [N-1:0]             best_score
);

  logic                run_r;
  logic [CLASS_W-1:0]  k_r;
  logic [CLASS_W-1:0]  best_cls_r;
  logic signed [N-1:0] best_val_r;
  logic signed [N-1:0] cand_s;
  logic                take_s;
  logic                last_s;

  // Candidate selection and strict signed compare; ties keep the lower index.
  always_comb begin
    cand_s     = scores[score_lsb(int'(k_r), N) +: N];
    take_s     = (cand_s > best_val_r);
    last_s     = (k_r == CLASS_W'(NUM_CLASSES - 1));
    done       = run_r & ce & last_s;
    best_class = take_s ? k_r : best_cls_r;
    best_score = take_s ? cand_s : best_val_r;
  end

  // Scan state: index, running best and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r      <= 1'b0;
      k_r        <= '0;
      best_cls_r <= '0;
      best_val_r <= '0;
    end else if (ce) begin
      if (start) begin
        run_r      <= 1'b1;
        k_r        <= CLASS_W'(1);
        best_cls_r <= '0;
        best_val_r <= scores[N-1:0];
      end else if (run_r) begin
        best_cls_r <= best_class;
        best_val_r <= best_score;
        if (last_s) begin
          run_r <= 1'b0;
          k_r   <= '0;
        end else begin
          k_r <= k_r + CLASS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cnn_classify_ctrl.sv
// cnn_classify_ctrl: frame sequencer and argmax classifier head for the
// streaming CNN chain.
// Ports:
//   clk, rst (sync, active-high), ce (global enable; 0 freezes all state)
//   start                       : begin a frame (only honoured in IDLE)
//   pix_vld/pix_din/pix_rdy     : input pixel handshake
//   net_vld/net_din             : pixel to the conv chain, 1 cycle after accept
//   net_dout/_vld/_end          : last-layer scores, class k at [k*N +: N]
//   busy                        : any state except IDLE
//   result_vld/_rdy/_class/_score : held classification result
//   timeout_err                 : one-cycle pulse when WAIT times out
// Optional: define CLASSIFY_PERF_CNT_EN to add frame_cycles[31:0], the
// saturating count of enabled cycles from leaving IDLE to entering HOLD.
module cnn_classify_ctrl
  import cnn_pkg::*;
#(
  parameter int N              = CNN_N,
  parameter int IN_CHANNEL     = 1,
  parameter int NUM_CLASSES    = CNN_NUM_CLASSES,
  parameter int FRAME_PIXELS   = 784,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLASS_W        = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     start,
  input  logic                     pix_vld,
  input  logic [IN_CHANNEL*N-1:0]  pix_din,
  output logic                     pix_rdy,
  output logic                     net_vld,
  output logic [IN_CHANNEL*N-1:0]  net_din,
  input  logic [NUM_CLASSES*N-1:0] net_dout,
  input  logic                     net_dout_vld,
  input  logic                     net_dout_end,
  output logic                     busy,
  output logic                     result_vld,
  input  logic                     result_rdy,
  output logic [CLASS_W-1:0]       result_class,
  output logic [N-1:0]             result_score,
  output logic                     timeout_err
`ifdef CLASSIFY_PERF_CNT_EN
  ,
  output logic [31:0]              frame_cycles
`endif
);

  localparam int PIX_W  = $clog2(FRAME_PIXELS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                   state_r, state_nx_s;
  logic [PIX_W-1:0]         pix_cnt_r;
  logic [WAIT_W-1:0]        wait_cnt_r;
  logic [NUM_CLASSES*N-1:0] score_r, score_cur_s;
  logic                     net_vld_r;
  logic [IN_CHANNEL*N-1:0]  net_din_r;
  logic                     timeout_err_r;
  logic                     result_vld_r;
  logic [CLASS_W-1:0]       result_class_r;
  logic [N-1:0]             result_score_r;
  logic                     hs_s, pix_last_s, wait_end_s, timeout_s;
  logic                     am_done_s;
  logic [CLASS_W-1:0]       am_class_s;
  logic [N-1:0]             am_score_s;

  // Handshake, end/timeout decode; an end in the timeout cycle wins.
  // score_cur_s lets argmax see a score vector captured in the same cycle as end.
  always_comb begin
    pix_rdy     = ce & (state_r == FEED);
    hs_s        = pix_rdy & pix_vld;
    pix_last_s  = (pix_cnt_r == PIX_W'(FRAME_PIXELS - 1));
    wait_end_s  = ce & (state_r == WAIT) & net_dout_end;
    timeout_s   = ce & (state_r == WAIT) & ~net_dout_end &
                  (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));
    score_cur_s = (ce && (state_r == WAIT) && net_dout_vld) ? net_dout : score_r;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (ce && start) state_nx_s = FEED;
        else             state_nx_s = IDLE;
      end
      FEED: begin
        if (hs_s && pix_last_s) state_nx_s = WAIT;
        else                    state_nx_s = FEED;
      end
      WAIT: begin
        if (wait_end_s)     state_nx_s = ARGMAX;
        else if (timeout_s) state_nx_s = IDLE;
        else                state_nx_s = WAIT;
      end
      ARGMAX: begin
        if (am_done_s) state_nx_s = HOLD;
        else           state_nx_s = ARGMAX;
      end
      HOLD: begin
        if (ce && result_rdy) state_nx_s = IDLE;
        else                  state_nx_s = HOLD;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)     state_r <= IDLE;
    else if (ce) state_r <= state_nx_s;
  end

  // Datapath registers: pixel pipe, counters, score capture, result.
  // timeout_err_r is refreshed every cycle so the pulse never stretches under ce=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r      <= '0;
      wait_cnt_r     <= '0;
      score_r        <= '0;
      net_vld_r      <= 1'b0;
      net_din_r      <= '0;
      timeout_err_r  <= 1'b0;
      result_vld_r   <= 1'b0;
      result_class_r <= '0;
      result_score_r <= '0;
    end else begin
      timeout_err_r <= timeout_s;
      if (ce) begin
        net_vld_r <= hs_s;
        if (hs_s) net_din_r <= pix_din;
        if ((state_r == IDLE) && start) pix_cnt_r <= '0;
        else if (hs_s)                  pix_cnt_r <= pix_cnt_r + PIX_W'(1);
        if (hs_s && pix_last_s)    wait_cnt_r <= '0;
        else if (state_r == WAIT)  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        if ((state_r == WAIT) && net_dout_vld) score_r <= net_dout;
        if (am_done_s) begin
          result_vld_r   <= 1'b1;
          result_class_r <= am_class_s;
          result_score_r <= am_score_s;
        end else if ((state_r == HOLD) && result_rdy) begin
          result_vld_r <= 1'b0;
        end
      end
    end
  end

  argmax_seq #(
    .N          (N),
    .NUM_CLASSES(NUM_CLASSES),
    .CLASS_W    (CLASS_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .start     (wait_end_s),
    .scores    (score_cur_s),
    .done      (am_done_s),
    .best_class(am_class_s),
    .best_score(am_score_s)
  );

  // A pixel registered before a ce=0 cycle is presented on the next enabled cycle.
  assign net_vld      = net_vld_r & ce;
  assign net_din      = net_din_r;
  assign busy         = (state_r != IDLE);
  assign result_vld   = result_vld_r;
  assign result_class = result_class_r;
  assign result_score = result_score_r;
  assign timeout_err  = timeout_err_r;

`ifdef CLASSIFY_PERF_CNT_EN
  logic [31:0] cyc_r, cyc_inc_s, frame_cycles_r;

  // Saturating increment.
  always_comb begin
    cyc_inc_s = (&cyc_r) ? cyc_r : cyc_r + 32'd1;
  end

  // Cycle counter over FEED/WAIT/ARGMAX, latched into frame_cycles on HOLD entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r          <= 32'd0;
      frame_cycles_r <= 32'd0;
    end else if (ce) begin
      if ((state_r == IDLE) && start)                     cyc_r <= 32'd0;
      else if (state_r inside {FEED, WAIT, ARGMAX})       cyc_r <= cyc_inc_s;
      if (am_done_s) frame_cycles_r <= cyc_inc_s;
    end
  end

  assign frame_cycles = frame_cycles_r;
`endif

endmodule

// File: tb/tb_cnn_classify_ctrl.sv
// Directed self-checking bench for cnn_classify_ctrl (16-pixel frames,
// 10 classes, 32-cycle timeout). The bench itself plays the conv chain.
module tb_cnn_classify_ctrl;

  localparam int N   = 8;
  localparam int NC  = 10;
  localparam int FP  = 16;
  localparam int TO  = 32;
  localparam int CW  = 4;

  typedef int sv_t [NC];

  logic          clk = 1'b0;
  logic          rst, ce, start, pix_vld, net_dout_vld, net_dout_end, result_rdy;
  logic [N-1:0]  pix_din;
  logic          pix_rdy, net_vld, busy, result_vld, timeout_err;
  logic [N-1:0]  net_din, result_score;
  logic [NC*N-1:0] net_dout;
  logic [CW-1:0] result_class;
`ifdef CLASSIFY_PERF_CNT_EN
  logic [31:0]   frame_cycles;
  int            perf_total = 0;
`endif

  int checks = 0;
  int failures = 0;
  sv_t sc_basic, sc_neg, sc_junk;

  cnn_classify_ctrl #(
    .N(N), .IN_CHANNEL(1), .NUM_CLASSES(NC), .FRAME_PIXELS(FP),
    .TIMEOUT_CYCLES(TO), .CLASS_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .pix_vld(pix_vld), .pix_din(pix_din), .pix_rdy(pix_rdy),
    .net_vld(net_vld), .net_din(net_din),
    .net_dout(net_dout), .net_dout_vld(net_dout_vld), .net_dout_end(net_dout_end),
    .busy(busy), .result_vld(result_vld), .result_rdy(result_rdy),
    .result_class(result_class), .result_score(result_score),
    .timeout_err(timeout_err)
`ifdef CLASSIFY_PERF_CNT_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

`ifdef CLASSIFY_PERF_CNT_EN
  // Independent measurement of enabled frame cycles from DUT status outputs.
  always @(negedge clk) begin
    if (!rst && ce && busy && !result_vld) perf_total <= perf_total + 1;
  end
`endif

  function automatic logic [NC*N-1:0] pack(input sv_t s);
    logic [NC*N-1:0] v;
    logic [N-1:0] b;
    v = '0;
    for (int k = 0; k < NC; k++) begin
      b = s[k][N-1:0];
      v[k*N +: N] = b;
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; ce = 1'b1; start = 1'b0; pix_vld = 1'b0; pix_din = '0;
    net_dout = '0; net_dout_vld = 1'b0; net_dout_end = 1'b0; result_rdy = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Start a frame and stream pixels base..base+FP-1 with ce=1 (no checks).
  task automatic feed_plain(input int base);
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < FP; i++) begin
      pix_vld = 1'b1; pix_din = N'(base + i); tick;
    end
    pix_vld = 1'b0;
  endtask

  // One chain output beat.
  task automatic send(input sv_t s, input logic vld, input logic fin);
    net_dout = pack(s); net_dout_vld = vld; net_dout_end = fin;
    tick;
    net_dout_vld = 1'b0; net_dout_end = 1'b0;
  endtask

  // Ticks until result_vld; -1 if it never comes within the bound.
  task automatic wait_result(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (result_vld) begin cycles = n; break; end
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (result_vld !== 1'b0) begin failures++; $display("FAIL reset_result_vld got=%0b exp=0", result_vld); end
    checks++; if (pix_rdy !== 1'b0 || net_vld !== 1'b0) begin failures++; $display("FAIL reset_rdy_vld got=%0b%0b exp=00", pix_rdy, net_vld); end
    checks++; if (timeout_err !== 1'b0 || result_class !== 4'd0 || result_score !== 8'd0) begin
      failures++; $display("FAIL reset_outputs got=%0b/%0d/%0d exp=0/0/0", timeout_err, result_class, result_score); end
  endtask

  task automatic test_basic;
    int cyc;
    start = 1'b1; tick; start = 1'b0;
    checks++; if (net_vld !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_start got=%0b/%0b exp=0/1", net_vld, busy); end
    for (int i = 0; i < FP; i++) begin
      pix_vld = 1'b1; pix_din = N'(i);
      #1;
      checks++; if (pix_rdy !== 1'b1) begin failures++; $display("FAIL basic_pix_rdy%0d got=%0b exp=1", i, pix_rdy); end
      tick;
      checks++; if (net_vld !== 1'b1 || net_din !== N'(i)) begin
        failures++; $display("FAIL basic_net%0d got=%0b/%0d exp=1/%0d", i, net_vld, net_din, i); end
    end
    pix_vld = 1'b0;
    #1;
    checks++; if (pix_rdy !== 1'b0) begin failures++; $display("FAIL basic_rdy_wait got=%0b exp=0", pix_rdy); end
    send(sc_basic, 1'b1, 1'b1);
    checks++; if (net_vld !== 1'b0) begin failures++; $display("FAIL basic_net_end got=%0b exp=0", net_vld); end
    wait_result(cyc);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", cyc); end
    checks++; if (result_class !== 4'd3 || result_score !== 8'd7) begin
      failures++; $display("FAIL basic_result got=%0d/%0d exp=3/7", result_class, $signed(result_score)); end
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
    checks++; if (result_vld !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_release got=%0b/%0b exp=0/0", result_vld, busy); end
  endtask

  task automatic test_negative;
    int cyc;
    feed_plain(40);
    send(sc_junk, 1'b1, 1'b0);   // overwritten by the next capture
    send(sc_neg, 1'b1, 1'b0);
    send(sc_neg, 1'b0, 1'b1);    // end after the last vld
    wait_result(cyc);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL neg_latency got=%0d exp=9", cyc); end
    checks++; if (result_class !== 4'd1 || result_score !== 8'hFF) begin
      failures++; $display("FAIL neg_result got=%0d/%0d exp=1/-1", result_class, $signed(result_score)); end
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc;
    int bad;
    feed_plain(0);
    send(sc_basic, 1'b1, 1'b1);
    wait_result(cyc);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL bp_latency got=%0d exp=9", cyc); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = 1'b1; result_rdy = 1'b0;
      tick;
      if (result_vld !== 1'b1 || result_class !== 4'd3 || result_score !== 8'd7 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
    checks++; if (result_vld !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got=%0b/%0b exp=0/0", result_vld, busy); end
  endtask

  task automatic test_timeout;
    int first, pulses, rv, busy_at;
    feed_plain(0);
    first = -1; pulses = 0; rv = 0; busy_at = 1;
    for (int j = 1; j <= 40; j++) begin
      net_dout_vld = (j == 3);   // a vld without end must not finish the frame
      net_dout = pack(sc_basic);
      tick;
      net_dout_vld = 1'b0;
      if (timeout_err) begin
        pulses++;
        if (first < 0) begin first = j; busy_at = busy; end
      end
      if (result_vld) rv++;
    end
    checks++; if (first !== 32) begin failures++; $display("FAIL to_when got=%0d exp=32", first); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL to_width got=%0d exp=1", pulses); end
    checks++; if (busy_at !== 0 || rv !== 0) begin failures++; $display("FAIL to_state got=%0d/%0d exp=0/0", busy_at, rv); end
  endtask

  task automatic test_end_at_timeout;
    int cyc;
    feed_plain(0);
    for (int j = 1; j <= 31; j++) tick;
    send(sc_neg, 1'b1, 1'b1);
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL eat_prio got=%0b/%0b exp=0/1", timeout_err, busy); end
    wait_result(cyc);
    checks++; if (cyc !== 9 || result_class !== 4'd1) begin
      failures++; $display("FAIL eat_result got=%0d/%0d exp=9/1", cyc, result_class); end
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
  endtask

  task automatic test_ce_toggle;
    int acc, bad, cyc;
    logic cev;
    start = 1'b1; tick; start = 1'b0;
    acc = 0; bad = 0; cev = 1'b0;
    for (int it = 0; it < 100 && acc < FP; it++) begin
      ce = cev; pix_vld = 1'b1; pix_din = N'(acc);
      #1;
      if (!cev && (pix_rdy !== 1'b0 || net_vld !== 1'b0)) bad++;
      tick;
      if (cev) acc++;
      cev = ~cev;
    end
    pix_vld = 1'b0; ce = 1'b1;
    checks++; if (acc !== FP || bad !== 0) begin failures++; $display("FAIL ce_feed got=%0d/%0d exp=%0d/0", acc, bad, FP); end
    send(sc_basic, 1'b1, 1'b1);
    cyc = -1; cev = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      ce = cev;
      #1;
      if (!cev && (pix_rdy !== 1'b0 || net_vld !== 1'b0)) bad++;
      tick;
      cev = ~cev;
      if (result_vld) begin cyc = n; break; end
    end
    ce = 1'b1;
    checks++; if (cyc !== 18 || bad !== 0) begin failures++; $display("FAIL ce_argmax got=%0d/%0d exp=18/0", cyc, bad); end
    checks++; if (result_class !== 4'd3 || result_score !== 8'd7) begin
      failures++; $display("FAIL ce_result got=%0d/%0d exp=3/7", result_class, $signed(result_score)); end
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int cyc;
`ifdef CLASSIFY_PERF_CNT_EN
    int p0;
`endif
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 7; i++) begin pix_vld = 1'b1; pix_din = N'(i); tick; end
    pix_din = N'(7); rst = 1'b1; tick; rst = 1'b0; pix_vld = 1'b0;
    checks++; if (busy !== 1'b0 || net_vld !== 1'b0 || result_vld !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=%0b/%0b/%0b exp=0/0/0", busy, net_vld, result_vld); end
`ifdef CLASSIFY_PERF_CNT_EN
    p0 = perf_total;
`endif
    feed_plain(100);
    send(sc_basic, 1'b1, 1'b1);
    wait_result(cyc);
    checks++; if (cyc !== 9 || result_class !== 4'd3 || result_score !== 8'd7) begin
      failures++; $display("FAIL rst_refeed got=%0d/%0d/%0d exp=9/3/7", cyc, result_class, $signed(result_score)); end
`ifdef CLASSIFY_PERF_CNT_EN
    checks++; if (frame_cycles !== 32'(perf_total - p0) || frame_cycles !== 32'd26) begin
      failures++; $display("FAIL perf_cnt got=%0d exp=%0d", frame_cycles, perf_total - p0); end
`endif
    result_rdy = 1'b1; tick; result_rdy = 1'b0;
  endtask

  initial begin
    sc_basic = '{-3, 5, 2, 7, 7, 0, 1, -5, 6, 0};
    sc_neg   = '{-128, -1, -2, -3, -4, -5, -6, -7, -8, -9};
    sc_junk  = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 127};
    test_reset;
    test_basic;
    test_negative;
    test_backpressure;
    test_timeout;
    test_end_at_timeout;
    test_ce_toggle;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
